// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the two requesters, the shared memory
// port and the arbiter.
//   m0_*/m1_*  : per-requester req/addr/wdata/we in, ready/rdata out
//   address/data_out/we/data_in : single synchronous memory port
//   gnt        : one-hot current owner (00 when idle)
// Modports: slave = arbiter side, master = requesters + memory side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req,   m1_req;
  logic [AW-1:0] m0_addr,  m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_we,    m1_we;
  logic          m0_ready, m1_ready;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in;
  logic          we;
  logic [1:0]    gnt;

  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we,
    input  data_in,
    output m0_ready, m1_ready, m0_rdata, m1_rdata,
    output address, data_out, we, gnt
  );

  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we,
    output data_in,
    input  m0_ready, m1_ready, m0_rdata, m1_rdata,
    input  address, data_out, we, gnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between two requesters.
// Each access runs IDLE (arbitrate + latch) -> ACCESS (bus driven, we for
// writes) -> RESP (read data returned, ready pulsed) -> IDLE.
// Ports:
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : mem_arbiter_if.slave (requester handshakes, memory port, gnt)
// Build option:
//   ARB_FIXED_PRIO_EN defined   -> m0 always wins a tie (m1 may starve)
//   ARB_FIXED_PRIO_EN undefined -> round-robin on ties (default)
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        r_state;
  logic          r_own;       // latched owner: 0 = m0, 1 = m1
  logic          r_we;        // latched access type, kept for RESP
  logic          r_bus_we;
  logic [AW-1:0] r_address;   // doubles as the latched request address
  logic [DW-1:0] r_data_out;  // doubles as the latched write data
  logic [1:0]    r_gnt;
  logic [1:0]    r_ready;
  logic [DW-1:0] r_rdata0, r_rdata1;
`ifndef ARB_FIXED_PRIO_EN
  logic          r_last;      // previous winner, 1 after reset so m0 wins first tie
`endif
  logic          w_win;       // winner of this IDLE cycle: 0 = m0, 1 = m1

  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    w_win = !bus.m0_req;
`else
    // Tie goes to the port that did not win last; a lone requester always wins.
    w_win = (bus.m0_req && bus.m1_req) ? !r_last : bus.m1_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_own      <= 1'b0;
      r_we       <= 1'b0;
      r_bus_we   <= 1'b0;
      r_address  <= '0;
      r_data_out <= '0;
      r_gnt      <= 2'b00;
      r_ready    <= 2'b00;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_last     <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            r_own      <= w_win;
            r_we       <= w_win ? bus.m1_we    : bus.m0_we;
            r_bus_we   <= w_win ? bus.m1_we    : bus.m0_we;
            r_address  <= w_win ? bus.m1_addr  : bus.m0_addr;
            r_data_out <= w_win ? bus.m1_wdata : bus.m0_wdata;
            r_gnt      <= w_win ? 2'b10 : 2'b01;
`ifndef ARB_FIXED_PRIO_EN
            r_last     <= w_win;
`endif
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          r_bus_we <= 1'b0;
          r_ready  <= r_own ? 2'b10 : 2'b01;
          r_state  <= RESP;
        end
        RESP: begin
          if (!r_we) begin
            if (r_own) r_rdata1 <= bus.data_in;
            else       r_rdata0 <= bus.data_in;
          end
          r_ready    <= 2'b00;
          r_gnt      <= 2'b00;
          r_address  <= '0;
          r_data_out <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory data only arrives during RESP, the same cycle ready is high, so the
  // owner's rdata bypasses data_in then; the register holds it afterwards.
  assign bus.m0_rdata = (r_state == RESP && !r_own && !r_we) ? bus.data_in : r_rdata0;
  assign bus.m1_rdata = (r_state == RESP &&  r_own && !r_we) ? bus.data_in : r_rdata1;
  assign bus.m0_ready = r_ready[0];
  assign bus.m1_ready = r_ready[1];
  assign bus.address  = r_address;
  assign bus.data_out = r_data_out;
  assign bus.we       = r_bus_we;
  assign bus.gnt      = r_gnt;

endmodule
